// File: rtl/opr1_sequencer.sv
// rtl/opr1_sequencer.sv - PDP-8 OPR group 1 microinstruction sequencer (optional BSW swap: OPR1_BSW_EN)
module opr1_sequencer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [7:0]  IR,
    input  logic [11:0] AC_IN,
    input  logic        L_IN,
    output logic [2:0]  ROT_OP,
    output logic [11:0] ROT_AI,
    output logic        ROT_LI,
    output logic        ROT_OE,
    input  logic [11:0] ROT_AO,
    input  logic        ROT_LO,
    output logic [11:0] AC_OUT,
    output logic        L_OUT,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_CMP  = 3'd2,
        S_INC  = 3'd3,
        S_ROT  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    localparam logic [2:0] ROP_PASS = 3'b000;
    localparam logic [2:0] ROP_SWAP = 3'b001;
    localparam logic [2:0] ROP_RAL  = 3'b010;
    localparam logic [2:0] ROP_RTL  = 3'b011;
    localparam logic [2:0] ROP_RAR  = 3'b100;
    localparam logic [2:0] ROP_RTR  = 3'b101;

    state_t      state_q, state_d;
    logic [11:0] ac_q, ac_d;
    logic        l_q, l_d;
    logic        cla_q, cla_d;
    logic        cll_q, cll_d;
    logic        cma_q, cma_d;
    logic        cml_q, cml_d;
    logic        iac_q, iac_d;
    logic [2:0]  rot_op_q, rot_op_d;

    logic [2:0]  start_rot_op;
    logic [12:0] inc_sum;

    // Rotate code is fixed at START; conflicting RAR+RAL collapses to pass (no ROT step).
    function automatic logic [2:0] decode_rot(input logic [7:0] ir);
        logic [2:0] op;
        op = ROP_PASS;
        if (ir[3] && ir[2]) begin
            op = ROP_PASS;
        end else if (ir[3]) begin
            op = ir[1] ? ROP_RTR : ROP_RAR;
        end else if (ir[2]) begin
            op = ir[1] ? ROP_RTL : ROP_RAL;
        end else if (ir[1]) begin
`ifdef OPR1_BSW_EN
            op = ROP_SWAP;
`else
            op = ROP_PASS;
`endif
        end
        return op;
    endfunction

    // First required step strictly after 'from', in PDP-8 event order; FIN if none remain.
    function automatic state_t next_step(input state_t from, input logic need_clr,
                                         input logic need_cmp, input logic need_inc,
                                         input logic need_rot);
        state_t nxt;
        nxt = S_FIN;
        if (from < S_CLR && need_clr) begin
            nxt = S_CLR;
        end else if (from < S_CMP && need_cmp) begin
            nxt = S_CMP;
        end else if (from < S_INC && need_inc) begin
            nxt = S_INC;
        end else if (from < S_ROT && need_rot) begin
            nxt = S_ROT;
        end
        return nxt;
    endfunction

    assign start_rot_op = decode_rot(IR);
    assign inc_sum      = {l_q, ac_q} + 13'd1;

    // Next-state and working-register update for each sequencer step.
    always_comb begin
        state_d  = state_q;
        ac_d     = ac_q;
        l_d      = l_q;
        cla_d    = cla_q;
        cll_d    = cll_q;
        cma_d    = cma_q;
        cml_d    = cml_q;
        iac_d    = iac_q;
        rot_op_d = rot_op_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    ac_d     = AC_IN;
                    l_d      = L_IN;
                    cla_d    = IR[7];
                    cll_d    = IR[6];
                    cma_d    = IR[5];
                    cml_d    = IR[4];
                    iac_d    = IR[0];
                    rot_op_d = start_rot_op;
                    state_d  = next_step(S_IDLE, IR[7] | IR[6], IR[5] | IR[4], IR[0],
                                         start_rot_op != ROP_PASS);
                end
            end
            S_CLR: begin
                if (cla_q) ac_d = 12'd0;
                if (cll_q) l_d = 1'b0;
                state_d = next_step(S_CLR, 1'b0, cma_q | cml_q, iac_q, rot_op_q != ROP_PASS);
            end
            S_CMP: begin
                if (cma_q) ac_d = ~ac_q;
                if (cml_q) l_d = ~l_q;
                state_d = next_step(S_CMP, 1'b0, 1'b0, iac_q, rot_op_q != ROP_PASS);
            end
            S_INC: begin
                // 13-bit increment: carry out of AC[11] lands in (complements) the link.
                {l_d, ac_d} = inc_sum;
                state_d = next_step(S_INC, 1'b0, 1'b0, 1'b0, rot_op_q != ROP_PASS);
            end
            S_ROT: begin
                ac_d    = ROT_AO;
                l_d     = ROT_LO;
                state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and working-register flops; reset wins over START and any active step.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            ac_q     <= 12'd0;
            l_q      <= 1'b0;
            cla_q    <= 1'b0;
            cll_q    <= 1'b0;
            cma_q    <= 1'b0;
            cml_q    <= 1'b0;
            iac_q    <= 1'b0;
            rot_op_q <= ROP_PASS;
        end else begin
            state_q  <= state_d;
            ac_q     <= ac_d;
            l_q      <= l_d;
            cla_q    <= cla_d;
            cll_q    <= cll_d;
            cma_q    <= cma_d;
            cml_q    <= cml_d;
            iac_q    <= iac_d;
            rot_op_q <= rot_op_d;
        end
    end

    // Rotater is only asked to act in ROT; its data inputs always follow the working pair.
    always_comb begin
        ROT_OP = (state_q == S_ROT) ? rot_op_q : ROP_PASS;
        ROT_OE = (state_q == S_ROT);
        ROT_AI = ac_q;
        ROT_LI = l_q;
        AC_OUT = ac_q;
        L_OUT  = l_q;
        BUSY   = (state_q != S_IDLE);
        DONE   = (state_q == S_FIN);
    end

endmodule

// File: tb/tb_opr1_sequencer.sv
// tb/tb_opr1_sequencer.sv - randomized self-checking bench for opr1_sequencer
module tb_opr1_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [7:0]  IR;
    logic [11:0] AC_IN;
    logic        L_IN;
    logic [2:0]  ROT_OP;
    logic [11:0] ROT_AI;
    logic        ROT_LI;
    logic        ROT_OE;
    logic [11:0] ROT_AO;
    logic        ROT_LO;
    logic [11:0] AC_OUT;
    logic        L_OUT;
    logic        BUSY;
    logic        DONE;

    int total = 0;
    int bad   = 0;

`ifdef OPR1_BSW_EN
    localparam bit BSW_EN = 1'b1;
`else
    localparam bit BSW_EN = 1'b0;
`endif

    opr1_sequencer dut (
        .CLK(CLK), .RESET(RESET), .START(START), .IR(IR), .AC_IN(AC_IN), .L_IN(L_IN),
        .ROT_OP(ROT_OP), .ROT_AI(ROT_AI), .ROT_LI(ROT_LI), .ROT_OE(ROT_OE),
        .ROT_AO(ROT_AO), .ROT_LO(ROT_LO), .AC_OUT(AC_OUT), .L_OUT(L_OUT),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Behavioural combinational rotater the sequencer drives.
    always_comb begin
        {ROT_LO, ROT_AO} = {ROT_LI, ROT_AI};
        case (ROT_OP)
            3'b001: ROT_AO = {ROT_AI[5:0], ROT_AI[11:6]};
            3'b010: {ROT_LO, ROT_AO} = {ROT_AI, ROT_LI};
            3'b011: {ROT_LO, ROT_AO} = {ROT_AI[10:0], ROT_LI, ROT_AI[11]};
            3'b100: {ROT_LO, ROT_AO} = {ROT_AI[0], ROT_LI, ROT_AI[11:1]};
            3'b101: {ROT_LO, ROT_AO} = {ROT_AI[1], ROT_AI[0], ROT_LI, ROT_AI[11:2]};
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: apply the PDP-8 event order on a 13-bit {L,AC} integer.
    task automatic ref_model(input logic [7:0] ir, input logic [11:0] ac, input logic l,
                             output logic [11:0] ac_o, output logic l_o,
                             output int nsteps, output int rop);
        int v;
        int rights;
        int lefts;
        bit swap;
        v = {19'd0, l, ac};
        nsteps = 0;
        if (ir[7] || ir[6]) begin
            nsteps++;
            if (ir[7]) v = v & 'h1000;
            if (ir[6]) v = v & 'h0FFF;
        end
        if (ir[5] || ir[4]) begin
            nsteps++;
            if (ir[5]) v = v ^ 'h0FFF;
            if (ir[4]) v = v ^ 'h1000;
        end
        if (ir[0]) begin
            nsteps++;
            v = (v + 1) % 8192;
        end
        rights = (ir[3] && !ir[2]) ? (ir[1] ? 2 : 1) : 0;
        lefts  = (ir[2] && !ir[3]) ? (ir[1] ? 2 : 1) : 0;
        swap   = !ir[3] && !ir[2] && ir[1] && BSW_EN;
        rop = 0;
        if (rights == 1) rop = 4;
        if (rights == 2) rop = 5;
        if (lefts == 1) rop = 2;
        if (lefts == 2) rop = 3;
        if (swap) rop = 1;
        for (int i = 0; i < rights; i++) v = ((v & 1) << 12) | (v >> 1);
        for (int i = 0; i < lefts; i++) v = ((v << 1) & 'h1FFF) | (v >> 12);
        if (swap) v = (v & 'h1000) | ((v & 'h3F) << 6) | ((v >> 6) & 'h3F);
        if (rop != 0) nsteps++;
        ac_o = v[11:0];
        l_o  = v[12];
    endtask

    task automatic run_op(input logic [7:0] ir, input logic [11:0] ac, input logic l,
                          input bit noise);
        logic [11:0] exp_ac;
        logic        exp_l;
        int          n;
        int          rop;
        int          rot_cycles;
        bit          seen;
        ref_model(ir, ac, l, exp_ac, exp_l, n, rop);
        @(negedge CLK);
        IR = ir; AC_IN = ac; L_IN = l; START = 1'b1;
        @(posedge CLK);
        seen = 1'b0;
        rot_cycles = 0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge CLK);
            check("busy", {31'd0, BUSY}, 32'd1);
            if (ROT_OE) begin
                rot_cycles++;
                check("rot_op", {29'd0, ROT_OP}, rop);
            end else begin
                check("rot_op_off", {29'd0, ROT_OP}, 32'd0);
            end
            if (DONE) begin
                seen = 1'b1;
                check("latency", c, n + 1);
                check("ac_out", {20'd0, AC_OUT}, {20'd0, exp_ac});
                check("l_out", {31'd0, L_OUT}, {31'd0, exp_l});
            end
            START = (noise && !DONE) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (START) begin
                IR = 8'($urandom);
                AC_IN = 12'($urandom);
                L_IN = 1'($urandom);
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        check("rot_oe_cycles", rot_cycles, (rop != 0) ? 1 : 0);
        @(negedge CLK);
        check("idle_busy", {31'd0, BUSY}, 32'd0);
        check("idle_done", {31'd0, DONE}, 32'd0);
        check("hold_ac", {20'd0, AC_OUT}, {20'd0, exp_ac});
        check("hold_l", {31'd0, L_OUT}, {31'd0, exp_l});
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; IR = 8'd0; AC_IN = 12'd0; L_IN = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_done", {31'd0, DONE}, 32'd0);
        check("rst_ac", {20'd0, AC_OUT}, 32'd0);
        check("rst_l", {31'd0, L_OUT}, 32'd0);
        check("rst_rot_op", {29'd0, ROT_OP}, 32'd0);
        check("rst_rot_oe", {31'd0, ROT_OE}, 32'd0);
        RESET = 1'b0;

        run_op(8'o240, 12'o1234, 1'b0, 1'b0);
        run_op(8'o001, 12'o7777, 1'b0, 1'b0);
        run_op(8'o006, 12'o4001, 1'b1, 1'b0);
        run_op(8'o002, 12'o1234, 1'b0, 1'b0);
        run_op(8'o211, 12'o5555, 1'b0, 1'b1);
        run_op(8'o014, 12'o0707, 1'b1, 1'b0);
        run_op(8'o000, 12'o4321, 1'b1, 1'b0);

        // Reset landing in the CMP cycle of a full CLR/CMP/INC sequence.
        @(negedge CLK);
        IR = 8'o377; AC_IN = 12'o1357; L_IN = 1'b1; START = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("abort_busy", {31'd0, BUSY}, 32'd0);
        check("abort_ac", {20'd0, AC_OUT}, 32'd0);
        check("abort_l", {31'd0, L_OUT}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("abort_no_done", {31'd0, DONE}, 32'd0);
        end

        for (int t = 0; t < 60; t++) begin
            run_op(8'($urandom), 12'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
